regfile_write_scheduler: RTL and testbench

Shares the single write port of the 32-entry `Register_File` between two writeback requesters: A (ALU result) and B (load data). Requesters are arbitrated round-robin through valid/ready handshakes. The winning write is registered onto the register-file write port. Two read-port forwarding muxes cover the cycle in which a granted write is being committed.

---
 rtl/regfile_write_scheduler_pkg.sv | 12 +
 rtl/regfile_write_scheduler_if.sv | 50 +++++
 rtl/regfile_write_scheduler_arbiter.sv | 44 ++++
 rtl/regfile_write_scheduler.sv | 65 ++++++
 tb/tb_regfile_write_scheduler.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/regfile_write_scheduler_pkg.sv
// rtl/regfile_write_scheduler_pkg.sv - shared types and constants for the regfile write scheduler
package regfile_sched_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } grant_t;

endpackage

// File: rtl/regfile_write_scheduler_if.sv
// rtl/regfile_write_scheduler_if.sv - requester handshakes, register-file write port and read ports
interface regfile_write_scheduler_if #(
    parameter int unsigned N = 32
);
    import regfile_sched_pkg::*;

    logic                  A_Valid_i;
    logic                  A_Ready_o;
    logic [REG_ADDR_W-1:0] A_Register_i;
    logic [N-1:0]          A_Data_i;

    logic                  B_Valid_i;
    logic                  B_Ready_o;
    logic [REG_ADDR_W-1:0] B_Register_i;
    logic [N-1:0]          B_Data_i;

    logic                  Stall_i;

    logic                  Reg_Write_o;
    logic [REG_ADDR_W-1:0] Write_Register_o;
    logic [N-1:0]          Write_Data_o;

    logic [REG_ADDR_W-1:0] Read_Register_1_i;
    logic [REG_ADDR_W-1:0] Read_Register_2_i;
    logic [N-1:0]          Read_Data_1_i;
    logic [N-1:0]          Read_Data_2_i;
    logic [N-1:0]          Read_Data_1_o;
    logic [N-1:0]          Read_Data_2_o;

    modport master (
        output A_Valid_i, A_Register_i, A_Data_i,
        output B_Valid_i, B_Register_i, B_Data_i,
        output Stall_i,
        output Read_Register_1_i, Read_Register_2_i, Read_Data_1_i, Read_Data_2_i,
        input  A_Ready_o, B_Ready_o,
        input  Reg_Write_o, Write_Register_o, Write_Data_o,
        input  Read_Data_1_o, Read_Data_2_o
    );

    modport slave (
        input  A_Valid_i, A_Register_i, A_Data_i,
        input  B_Valid_i, B_Register_i, B_Data_i,
        input  Stall_i,
        input  Read_Register_1_i, Read_Register_2_i, Read_Data_1_i, Read_Data_2_i,
        output A_Ready_o, B_Ready_o,
        output Reg_Write_o, Write_Register_o, Write_Data_o,
        output Read_Data_1_o, Read_Data_2_o
    );

endinterface

// File: rtl/regfile_write_scheduler_arbiter.sv
// rtl/regfile_write_scheduler_arbiter.sv - two-requester round-robin arbiter with stall
module rr_arbiter2
    import regfile_sched_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic a_valid,
    input  logic b_valid,
    input  logic stall,
    output logic a_grant,
    output logic b_grant
);

    grant_t last_grant;
    grant_t last_grant_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant <= GRANT_B;
        end else begin
            last_grant <= last_grant_next;
        end
    end

    // Grants are masked by reset so no handshake can complete while it is held.
    always_comb begin
        a_grant         = 1'b0;
        b_grant         = 1'b0;
        last_grant_next = last_grant;
        if (reset && !stall) begin
            if (a_valid && (!b_valid || last_grant == GRANT_B)) begin
                a_grant = 1'b1;
            end else if (b_valid) begin
                b_grant = 1'b1;
            end
        end
        if (a_grant) begin
            last_grant_next = GRANT_A;
        end else if (b_grant) begin
            last_grant_next = GRANT_B;
        end
    end

endmodule

// File: rtl/regfile_write_scheduler.sv
// rtl/regfile_write_scheduler.sv - arbitrates two writeback requesters onto one register-file write port
module regfile_write_scheduler
    import regfile_sched_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input logic clk,
    input logic reset,
    regfile_write_scheduler_if.slave bus
);

    logic                  a_grant;
    logic                  b_grant;
    logic                  reg_write;
    logic [REG_ADDR_W-1:0] write_register;
    logic [N-1:0]          write_data;

    rr_arbiter2 u_arbiter (
        .clk     (clk),
        .reset   (reset),
        .a_valid (bus.A_Valid_i),
        .b_valid (bus.B_Valid_i),
        .stall   (bus.Stall_i),
        .a_grant (a_grant),
        .b_grant (b_grant)
    );

    assign bus.A_Ready_o = a_grant;
    assign bus.B_Ready_o = b_grant;

    // Writes to register zero are accepted but never enable the write port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            reg_write      <= 1'b0;
            write_register <= REG_ZERO;
            write_data     <= '0;
        end else if (bus.A_Valid_i && a_grant) begin
            reg_write      <= (bus.A_Register_i != REG_ZERO);
            write_register <= bus.A_Register_i;
            write_data     <= bus.A_Data_i;
        end else if (bus.B_Valid_i && b_grant) begin
            reg_write      <= (bus.B_Register_i != REG_ZERO);
            write_register <= bus.B_Register_i;
            write_data     <= bus.B_Data_i;
        end else begin
            reg_write      <= 1'b0;
        end
    end

    assign bus.Reg_Write_o      = reg_write;
    assign bus.Write_Register_o = write_register;
    assign bus.Write_Data_o     = write_data;

    always_comb begin
        bus.Read_Data_1_o = bus.Read_Data_1_i;
        bus.Read_Data_2_o = bus.Read_Data_2_i;
        if (reg_write && write_register == bus.Read_Register_1_i) begin
            bus.Read_Data_1_o = write_data;
        end
        if (reg_write && write_register == bus.Read_Register_2_i) begin
            bus.Read_Data_2_o = write_data;
        end
    end

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// tb/tb_regfile_write_scheduler.sv - directed self-checking bench for regfile_write_scheduler
module tb_regfile_write_scheduler;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    regfile_write_scheduler_if #(.N(32)) bus ();

    regfile_write_scheduler #(.N(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset                 = 1'b0;
        bus.A_Valid_i         = 1'b1;
        bus.A_Register_i      = 5'd2;
        bus.A_Data_i          = 32'd7;
        bus.B_Valid_i         = 1'b1;
        bus.B_Register_i      = 5'd9;
        bus.B_Data_i          = 32'd9;
        bus.Stall_i           = 1'b0;
        bus.Read_Register_1_i = 5'd2;
        bus.Read_Register_2_i = 5'd3;
        bus.Read_Data_1_i     = 32'hdead;
        bus.Read_Data_2_i     = 32'hbeef;

        // Reset held with both valids high
        edge_step();
        edge_step();
        chk("rst_a_ready", {31'd0, bus.A_Ready_o}, 32'd0);
        chk("rst_b_ready", {31'd0, bus.B_Ready_o}, 32'd0);
        chk("rst_reg_write", {31'd0, bus.Reg_Write_o}, 32'd0);
        chk("rst_wr_reg", {27'd0, bus.Write_Register_o}, 32'd0);
        chk("rst_wr_data", bus.Write_Data_o, 32'd0);
        chk("rst_rd1_passthru", bus.Read_Data_1_o, 32'hdead);

        reset = 1'b1;
        #1;
        chk("rel_a_ready", {31'd0, bus.A_Ready_o}, 32'd1);
        chk("rel_b_ready", {31'd0, bus.B_Ready_o}, 32'd0);

        // A: reg 2 <- 7, then forwarding on port 1
        edge_step();
        bus.A_Valid_i = 1'b0;
        #1;
        chk("a_reg_write", {31'd0, bus.Reg_Write_o}, 32'd1);
        chk("a_wr_reg", {27'd0, bus.Write_Register_o}, 32'd2);
        chk("a_wr_data", bus.Write_Data_o, 32'd7);
        chk("a_fwd_rd1", bus.Read_Data_1_o, 32'd7);
        chk("a_nofwd_rd2", bus.Read_Data_2_o, 32'hbeef);
        chk("b_ready_alone", {31'd0, bus.B_Ready_o}, 32'd1);
        chk("a_ready_low", {31'd0, bus.A_Ready_o}, 32'd0);

        edge_step();
        bus.B_Valid_i = 1'b0;
        #1;
        chk("b_wr_reg", {27'd0, bus.Write_Register_o}, 32'd9);
        chk("b_wr_data", bus.Write_Data_o, 32'd9);
        chk("rd1_after_commit", bus.Read_Data_1_o, 32'hdead);

        edge_step();
        chk("idle_reg_write", {31'd0, bus.Reg_Write_o}, 32'd0);
        chk("idle_hold_reg", {27'd0, bus.Write_Register_o}, 32'd9);

        // Contention: A reg 4 from 20, B reg 25 from 6, new data each transfer
        bus.A_Valid_i    = 1'b1;
        bus.A_Register_i = 5'd4;
        bus.A_Data_i     = 32'd20;
        bus.B_Valid_i    = 1'b1;
        bus.B_Register_i = 5'd25;
        bus.B_Data_i     = 32'd6;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("cont_a_ready_%0d", i), {31'd0, bus.A_Ready_o}, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("cont_b_ready_%0d", i), {31'd0, bus.B_Ready_o}, (i % 2 == 0) ? 32'd0 : 32'd1);
            edge_step();
            if (i % 2 == 0) bus.A_Data_i = bus.A_Data_i + 32'd1;
            else            bus.B_Data_i = bus.B_Data_i + 32'd1;
            if (i == 3) begin
                bus.A_Valid_i = 1'b0;
                bus.B_Valid_i = 1'b0;
            end
            #1;
            chk($sformatf("cont_wr_reg_%0d", i), {27'd0, bus.Write_Register_o}, (i % 2 == 0) ? 32'd4 : 32'd25);
            chk($sformatf("cont_wr_data_%0d", i), bus.Write_Data_o, (i == 0) ? 32'd20 : (i == 1) ? 32'd6 : (i == 2) ? 32'd21 : 32'd7);
            chk($sformatf("cont_reg_write_%0d", i), {31'd0, bus.Reg_Write_o}, 32'd1);
        end

        // Register zero: B writes reg 0 <- 78
        bus.B_Valid_i         = 1'b1;
        bus.B_Register_i      = 5'd0;
        bus.B_Data_i          = 32'd78;
        bus.Read_Register_1_i = 5'd0;
        bus.Read_Data_1_i     = 32'h1234;
        #1;
        chk("z_b_ready", {31'd0, bus.B_Ready_o}, 32'd1);
        edge_step();
        bus.B_Valid_i = 1'b0;
        #1;
        chk("z_reg_write", {31'd0, bus.Reg_Write_o}, 32'd0);
        chk("z_wr_reg", {27'd0, bus.Write_Register_o}, 32'd0);
        chk("z_wr_data", bus.Write_Data_o, 32'd78);
        chk("z_rd1_nofwd", bus.Read_Data_1_o, 32'h1234);

        // Stall: both valid for 3 stalled cycles; last grant was B so A goes first
        bus.A_Valid_i    = 1'b1;
        bus.A_Register_i = 5'd5;
        bus.A_Data_i     = 32'd50;
        bus.B_Valid_i    = 1'b1;
        bus.B_Register_i = 5'd6;
        bus.B_Data_i     = 32'd60;
        bus.Stall_i      = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("stall_a_ready_%0d", i), {31'd0, bus.A_Ready_o}, 32'd0);
            chk($sformatf("stall_b_ready_%0d", i), {31'd0, bus.B_Ready_o}, 32'd0);
            edge_step();
            chk($sformatf("stall_reg_write_%0d", i), {31'd0, bus.Reg_Write_o}, 32'd0);
        end
        bus.Stall_i = 1'b0;
        #1;
        chk("unstall_a_ready", {31'd0, bus.A_Ready_o}, 32'd1);
        edge_step();
        bus.A_Valid_i = 1'b0;
        #1;
        chk("unstall_wr_reg_a", {27'd0, bus.Write_Register_o}, 32'd5);
        chk("unstall_wr_data_a", bus.Write_Data_o, 32'd50);
        chk("unstall_b_ready", {31'd0, bus.B_Ready_o}, 32'd1);
        edge_step();
        bus.B_Valid_i = 1'b0;
        #1;
        chk("unstall_wr_reg_b", {27'd0, bus.Write_Register_o}, 32'd6);
        chk("unstall_wr_data_b", bus.Write_Data_o, 32'd60);

        // Reset mid-write: A reg 31 <- 78, both read ports on 31
        bus.A_Valid_i         = 1'b1;
        bus.A_Register_i      = 5'd31;
        bus.A_Data_i          = 32'd78;
        bus.Read_Register_1_i = 5'd31;
        bus.Read_Register_2_i = 5'd31;
        bus.Read_Data_1_i     = 32'h11;
        bus.Read_Data_2_i     = 32'h22;
        #1;
        chk("mid_a_ready", {31'd0, bus.A_Ready_o}, 32'd1);
        edge_step();
        bus.A_Valid_i = 1'b0;
        #1;
        chk("mid_reg_write", {31'd0, bus.Reg_Write_o}, 32'd1);
        chk("mid_fwd_rd1", bus.Read_Data_1_o, 32'd78);
        chk("mid_fwd_rd2", bus.Read_Data_2_o, 32'd78);
        reset = 1'b0;
        #1;
        chk("mid_rst_reg_write", {31'd0, bus.Reg_Write_o}, 32'd0);
        chk("mid_rst_rd1", bus.Read_Data_1_o, 32'h11);
        chk("mid_rst_rd2", bus.Read_Data_2_o, 32'h22);
        chk("mid_rst_wr_reg", {27'd0, bus.Write_Register_o}, 32'd0);

        // After release A has priority again even though A won last
        edge_step();
        bus.A_Valid_i = 1'b1;
        bus.B_Valid_i = 1'b1;
        reset         = 1'b1;
        #1;
        chk("post_rst_a_ready", {31'd0, bus.A_Ready_o}, 32'd1);
        chk("post_rst_b_ready", {31'd0, bus.B_Ready_o}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
